// File: rtl/hex_memory.sv
// hex_memory: unified program/data memory with byte-stream boot loader; define HEX_MEM_CLEAR_EN to zero storage after reset
module hex_memory #(
  parameter int MEM_ADDR_WIDTH = 20,
  parameter int MEM_WORDS = 65536
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ld_valid,
  output logic                      o_ld_ready,
  input  logic [7:0]                i_ld_data,
  output logic                      o_cpu_rst,
  output logic                      o_loaded,
  output logic                      o_ld_error,
  input  logic                      i_f_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] i_f_addr,
  output logic [7:0]                o_f_data,
  input  logic                      i_d_valid,
  input  logic                      i_d_we,
  input  logic [MEM_ADDR_WIDTH-3:0] i_d_addr,
  input  logic [31:0]               i_d_data,
  output logic [31:0]               o_d_data
);
  localparam int IW = $clog2(MEM_WORDS);
  typedef enum logic [2:0] {LOAD_LEN, LOAD_DATA, RUN, ERROR, CLEAR} state_t;
  state_t state;
  logic [31:0] mem [MEM_WORDS];
  logic [1:0] bcnt;
  logic [23:0] sh;
  logic [31:0] len, wcnt, word, f_word, f_sh, wd;
  logic beat, run, f_in, d_in, we;
  logic [IW-1:0] wa;
  assign beat = i_ld_valid & o_ld_ready;
  assign word = {i_ld_data, sh};
  assign run = state == RUN;
  assign f_in = 32'(i_f_addr[MEM_ADDR_WIDTH-1:2]) < 32'(MEM_WORDS);
  assign d_in = 32'(i_d_addr) < 32'(MEM_WORDS);
  assign f_word = mem[i_f_addr[IW+1:2]];
  assign f_sh = f_word >> {i_f_addr[1:0], 3'b000};
  assign o_f_data = (i_f_valid & run & f_in) ? f_sh[7:0] : '0;
  assign o_d_data = (i_d_valid & ~i_d_we & run & d_in) ? mem[i_d_addr[IW-1:0]] : '0;
  // Each state owns the single write port: loader, processor stores, or clear sweep
  assign we = (state == LOAD_DATA) ? beat && bcnt == 2'd3 : run ? i_d_valid & i_d_we & d_in : state == CLEAR;
  assign wa = run ? i_d_addr[IW-1:0] : wcnt[IW-1:0];
  assign wd = run ? i_d_data : (state == CLEAR) ? '0 : word;
  // Storage write, no reset so the array maps onto RAM
  always_ff @(posedge i_clk) begin
    if (we) mem[wa] <= wd;
  end
  // Boot FSM: length header, packed image words, then hand over to the processor
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
`ifdef HEX_MEM_CLEAR_EN
      state <= CLEAR;
`else
      state <= LOAD_LEN;
`endif
      bcnt <= '0;
      sh <= '0;
      len <= '0;
      wcnt <= '0;
      o_ld_ready <= 1'b0;
      o_cpu_rst <= 1'b1;
      o_loaded <= 1'b0;
      o_ld_error <= 1'b0;
    end else begin
      case (state)
`ifdef HEX_MEM_CLEAR_EN
        CLEAR: begin
          wcnt <= (wcnt == 32'(MEM_WORDS - 1)) ? '0 : wcnt + 32'd1;
          if (wcnt == 32'(MEM_WORDS - 1)) begin
            state <= LOAD_LEN;
            o_ld_ready <= 1'b1;
          end
        end
`endif
        LOAD_LEN: begin
          o_ld_ready <= 1'b1;
          if (beat) begin
            bcnt <= bcnt + 2'd1;
            sh <= {i_ld_data, sh[23:8]};
            if (bcnt == 2'd3) begin
              len <= word;
              if (word == '0) begin
                state <= RUN;
                o_ld_ready <= 1'b0;
                o_cpu_rst <= 1'b0;
                o_loaded <= 1'b1;
              end else if (word > 32'(MEM_WORDS)) begin
                state <= ERROR;
                o_ld_ready <= 1'b0;
                o_ld_error <= 1'b1;
              end else begin
                state <= LOAD_DATA;
              end
            end
          end
        end
        LOAD_DATA: begin
          if (beat) begin
            bcnt <= bcnt + 2'd1;
            sh <= {i_ld_data, sh[23:8]};
            if (bcnt == 2'd3) begin
              wcnt <= wcnt + 32'd1;
              if (wcnt + 32'd1 == len) begin
                state <= RUN;
                o_ld_ready <= 1'b0;
                o_cpu_rst <= 1'b0;
                o_loaded <= 1'b1;
              end
            end
          end
        end
        RUN, ERROR: state <= state;
        default: state <= LOAD_LEN;
      endcase
    end
  end
endmodule
